axis_apb_requester: RTL and testbench

Stream-to-APB bridge that executes command frames arriving on a 32-bit valid/ready stream as APB transactions and returns response frames. It is the initiator end of the on-chip APB fabric: it drives the root APB bridge's upstream port when management traffic (SCCB link or Ethernet management path) accesses peripherals. It supports single- and multi-beat reads and writes with address auto-increment, and reports slave errors and framing errors in-band.

---
 rtl/apb_requester_pkg.sv | 35 +++
 rtl/axis_apb_requester.sv | 213 +++++++++++++++++++++
 tb/tb_axis_apb_requester.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_requester_pkg.sv
// Shared types and field positions for the stream-to-APB requester.
package apb_requester_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WDATA,
      S_SETUP,
      S_ACCESS,
      S_RDATA,
      S_STATUS,
      S_DRAIN
   } state_e;

   localparam int unsigned HDR_WRITE_BIT = 31;
   localparam int unsigned HDR_COUNT_LSB = 0;
   localparam int unsigned HDR_COUNT_W   = 8;

   localparam int unsigned ST_ERR_BIT    = 31;
   localparam int unsigned ST_TO_BIT     = 30;
   localparam int unsigned ST_FR_BIT     = 29;
   localparam int unsigned ST_BEATS_W    = 9;

   function automatic logic [31:0] status_word(input logic err, input logic to,
                                               input logic fr, input logic [ST_BEATS_W-1:0] beats);
      logic [31:0] w;
      w = '0;
      w[ST_ERR_BIT] = err;
      w[ST_TO_BIT]  = to;
      w[ST_FR_BIT]  = fr;
      w[ST_BEATS_W-1:0] = beats;
      return w;
   endfunction

endpackage

// File: rtl/axis_apb_requester.sv
// Executes command frames from a 32-bit stream as APB transfers and returns response frames.
// Optional ACCESS-phase timeout enabled by defining APB_REQUESTER_TIMEOUT_EN.
module axis_apb_requester
   import apb_requester_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = 32,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  cmd_tvalid,
   output logic                  cmd_tready,
   input  logic                  cmd_tlast,
   input  logic [31:0]           cmd_tdata,
   output logic                  rsp_tvalid,
   input  logic                  rsp_tready,
   output logic                  rsp_tlast,
   output logic [31:0]           rsp_tdata,
   output logic                  psel,
   output logic                  penable,
   output logic                  pwrite,
   output logic [ADDR_WIDTH-1:0] paddr,
   output logic [31:0]           pwdata,
   output logic [3:0]            pstrb,
   input  logic [31:0]           prdata,
   input  logic                  pready,
   input  logic                  pslverr,
   output logic                  busy
);

   state_e                  state_q;
   logic                    wr_q, last_q, err_q, to_q, fr_q, busy_q;
   logic [HDR_COUNT_W-1:0]  cnt_q;
   logic [ST_BEATS_W-1:0]   beats_q;
   logic                    psel_q, penable_q, pwrite_q;
   logic [ADDR_WIDTH-1:0]   paddr_q;
   logic [31:0]             pwdata_q, rsp_tdata_q;
   logic [3:0]              pstrb_q;
   logic                    rsp_tvalid_q, rsp_tlast_q;
   logic                    timeout_hit, beat_fail, is_final;

`ifdef APB_REQUESTER_TIMEOUT_EN
   localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] to_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     to_cnt_q <= '0;
      else if (state_q == S_SETUP)  to_cnt_q <= '0;
      else if (state_q == S_ACCESS) to_cnt_q <= to_cnt_q + TO_W'(1);
   end

   assign timeout_hit = (state_q == S_ACCESS) && !pready &&
                        (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout_hit = 1'b0;
`endif

   assign beat_fail  = timeout_hit || (pready && pslverr);
   assign is_final   = (beats_q == {1'b0, cnt_q});
   assign cmd_tready = !rst && (state_q inside {S_IDLE, S_ADDR, S_WDATA, S_DRAIN});

   assign psel       = psel_q;
   assign penable    = penable_q;
   assign pwrite     = pwrite_q;
   assign paddr      = paddr_q;
   assign pwdata     = pwdata_q;
   assign pstrb      = pstrb_q;
   assign rsp_tvalid = rsp_tvalid_q;
   assign rsp_tlast  = rsp_tlast_q;
   assign rsp_tdata  = rsp_tdata_q;
   assign busy       = busy_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         wr_q         <= 1'b0;
         last_q       <= 1'b0;
         err_q        <= 1'b0;
         to_q         <= 1'b0;
         fr_q         <= 1'b0;
         busy_q       <= 1'b0;
         cnt_q        <= '0;
         beats_q      <= '0;
         psel_q       <= 1'b0;
         penable_q    <= 1'b0;
         pwrite_q     <= 1'b0;
         paddr_q      <= '0;
         pwdata_q     <= '0;
         pstrb_q      <= '0;
         rsp_tvalid_q <= 1'b0;
         rsp_tlast_q  <= 1'b0;
         rsp_tdata_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (cmd_tvalid) begin
               wr_q    <= cmd_tdata[HDR_WRITE_BIT];
               cnt_q   <= cmd_tdata[HDR_COUNT_LSB +: HDR_COUNT_W];
               beats_q <= '0;
               err_q   <= cmd_tlast;
               fr_q    <= cmd_tlast;
               to_q    <= 1'b0;
               busy_q  <= 1'b1;
               if (cmd_tlast) begin
                  state_q      <= S_STATUS;
                  rsp_tvalid_q <= 1'b1;
                  rsp_tlast_q  <= 1'b1;
                  rsp_tdata_q  <= status_word(1'b1, 1'b0, 1'b1, '0);
               end else begin
                  state_q <= S_ADDR;
               end
            end
            S_ADDR: if (cmd_tvalid) begin
               paddr_q <= cmd_tdata[ADDR_WIDTH-1:0];
               if (wr_q && cmd_tlast) begin
                  err_q        <= 1'b1;
                  fr_q         <= 1'b1;
                  state_q      <= S_STATUS;
                  rsp_tvalid_q <= 1'b1;
                  rsp_tlast_q  <= 1'b1;
                  rsp_tdata_q  <= status_word(1'b1, 1'b0, 1'b1, '0);
               end else if (wr_q) begin
                  state_q <= S_WDATA;
               end else if (cmd_tlast) begin
                  pwrite_q <= 1'b0;
                  pstrb_q  <= 4'h0;
                  psel_q   <= 1'b1;
                  state_q  <= S_SETUP;
               end else begin
                  err_q   <= 1'b1;
                  fr_q    <= 1'b1;
                  state_q <= S_DRAIN;
               end
            end
            S_WDATA: if (cmd_tvalid) begin
               pwdata_q <= cmd_tdata;
               last_q   <= cmd_tlast;
               pwrite_q <= 1'b1;
               pstrb_q  <= 4'hF;
               psel_q   <= 1'b1;
               state_q  <= S_SETUP;
            end
            S_SETUP: begin
               penable_q <= 1'b1;
               state_q   <= S_ACCESS;
            end
            S_ACCESS: if (pready || timeout_hit) begin
               psel_q    <= 1'b0;
               penable_q <= 1'b0;
               if (beat_fail) begin
                  // A write whose word was not the frame end must still swallow the rest of the frame.
                  err_q <= 1'b1;
                  to_q  <= timeout_hit;
                  if (wr_q && !last_q) begin
                     state_q <= S_DRAIN;
                  end else begin
                     state_q      <= S_STATUS;
                     rsp_tvalid_q <= 1'b1;
                     rsp_tlast_q  <= 1'b1;
                     rsp_tdata_q  <= status_word(1'b1, timeout_hit, 1'b0, beats_q);
                  end
               end else begin
                  beats_q <= beats_q + 9'd1;
                  paddr_q <= paddr_q + ADDR_WIDTH'(4);
                  if (!wr_q) begin
                     state_q      <= S_RDATA;
                     rsp_tvalid_q <= 1'b1;
                     rsp_tlast_q  <= 1'b0;
                     rsp_tdata_q  <= prdata;
                  end else if (last_q) begin
                     err_q        <= !is_final;
                     fr_q         <= !is_final;
                     state_q      <= S_STATUS;
                     rsp_tvalid_q <= 1'b1;
                     rsp_tlast_q  <= 1'b1;
                     rsp_tdata_q  <= status_word(!is_final, 1'b0, !is_final, beats_q + 9'd1);
                  end else if (is_final) begin
                     err_q   <= 1'b1;
                     fr_q    <= 1'b1;
                     state_q <= S_DRAIN;
                  end else begin
                     state_q <= S_WDATA;
                  end
               end
            end
            S_RDATA: if (rsp_tready) begin
               if (beats_q == ({1'b0, cnt_q} + 9'd1)) begin
                  state_q     <= S_STATUS;
                  rsp_tlast_q <= 1'b1;
                  rsp_tdata_q <= status_word(1'b0, 1'b0, 1'b0, beats_q);
               end else begin
                  rsp_tvalid_q <= 1'b0;
                  psel_q       <= 1'b1;
                  state_q      <= S_SETUP;
               end
            end
            S_STATUS: if (rsp_tready) begin
               rsp_tvalid_q <= 1'b0;
               rsp_tlast_q  <= 1'b0;
               busy_q       <= 1'b0;
               state_q      <= S_IDLE;
            end
            S_DRAIN: if (cmd_tvalid && cmd_tlast) begin
               state_q      <= S_STATUS;
               rsp_tvalid_q <= 1'b1;
               rsp_tlast_q  <= 1'b1;
               rsp_tdata_q  <= status_word(err_q, to_q, fr_q, beats_q);
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axis_apb_requester.sv
// Scoreboard bench for axis_apb_requester: directed frames, APB slave model, response monitor.
module tb_axis_apb_requester;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_tvalid = 1'b0, cmd_tlast = 1'b0;
   logic [31:0] cmd_tdata = '0;
   logic        cmd_tready;
   logic        rsp_tvalid, rsp_tlast;
   logic        rsp_tready = 1'b1;
   logic [31:0] rsp_tdata;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata;
   logic [3:0]  pstrb;
   logic [31:0] prdata = '0;
   logic        pready = 1'b0, pslverr = 1'b0;
   logic        busy;

   axis_apb_requester #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tlast(cmd_tlast), .cmd_tdata(cmd_tdata),
      .rsp_tvalid(rsp_tvalid), .rsp_tready(rsp_tready), .rsp_tlast(rsp_tlast), .rsp_tdata(rsp_tdata),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata), .pready(pready), .pslverr(pslverr), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] d; logic l; } rsp_t;
   typedef struct { logic w; logic [31:0] a; logic [31:0] d; } apb_t;
   rsp_t rsp_q[$];
   apb_t apb_q[$];

   int total = 0;
   int bad = 0;
   int slv_wait = 0;
   int err_beat = -1;
   int beat_idx = 0;
   int acc_cnt = 0;
   int last_run = 0;
   bit stall_mode = 1'b0;
   int stall_cnt = 0;
   bit prev_pending = 1'b0;
   logic [31:0] prev_data = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic exp_rsp(input logic [31:0] d, input logic l);
      rsp_t r;
      r.d = d; r.l = l;
      rsp_q.push_back(r);
   endtask

   task automatic exp_apb(input logic w, input logic [31:0] a, input logic [31:0] d);
      apb_t t;
      t.w = w; t.a = a; t.d = d;
      apb_q.push_back(t);
   endtask

   // Monitor and APB slave model, evaluated between active edges.
   always @(negedge clk) begin
      if (rst) begin
         pready = 1'b0; pslverr = 1'b0; acc_cnt = 0; prev_pending = 1'b0;
      end else begin
         if (prev_pending) begin
            chk("rsp_hold_valid", 32'(rsp_tvalid), 32'd1);
            chk("rsp_hold_data", rsp_tdata, prev_data);
         end
         if (rsp_tvalid) chk("psel_while_pending", 32'(psel), 32'd0);
         if (rsp_tvalid && rsp_tready) begin
            if (rsp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL rsp_unexpected: got %h expected none", rsp_tdata);
            end else begin
               rsp_t e;
               e = rsp_q.pop_front();
               chk("rsp_data", rsp_tdata, e.d);
               chk("rsp_last", 32'(rsp_tlast), 32'(e.l));
            end
         end
         prev_pending = rsp_tvalid && !rsp_tready;
         prev_data    = rsp_tdata;

         if (psel && penable) begin
            acc_cnt++;
            if (acc_cnt > slv_wait) begin
               pready  = 1'b1;
               pslverr = (beat_idx == err_beat);
               prdata  = 32'h10 + 32'(beat_idx);
               if (apb_q.size() == 0) begin
                  total++; bad++;
                  $display("FAIL apb_unexpected: got addr %h expected none", paddr);
               end else begin
                  apb_t e;
                  e = apb_q.pop_front();
                  chk("apb_addr", paddr, e.a);
                  chk("apb_write", 32'(pwrite), 32'(e.w));
                  if (e.w) begin
                     chk("apb_wdata", pwdata, e.d);
                     chk("apb_pstrb", 32'(pstrb), 32'hF);
                  end else begin
                     chk("apb_pstrb", 32'(pstrb), 32'h0);
                  end
               end
               beat_idx++;
            end else begin
               pready = 1'b0;
            end
         end else begin
            if (acc_cnt > 0) last_run = acc_cnt;
            acc_cnt = 0; pready = 1'b0; pslverr = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk); #1;
         if (!stall_mode) rsp_tready = 1'b1;
         else if (rsp_tready) rsp_tready = 1'b0;
         else if (rsp_tvalid) begin
            if (stall_cnt >= 5) begin rsp_tready = 1'b1; stall_cnt = 0; end
            else stall_cnt++;
         end
      end
   end

   task automatic send(input logic [31:0] d, input logic l);
      int n;
      n = 0;
      cmd_tdata = d; cmd_tlast = l; cmd_tvalid = 1'b1;
      do begin @(negedge clk); n++; end while (!cmd_tready && n < 200);
      if (!cmd_tready) begin
         total++; bad++;
         $display("FAIL cmd_accept_timeout: got tready 0 expected 1");
      end
      @(posedge clk); #1;
      cmd_tvalid = 1'b0; cmd_tlast = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      do begin @(negedge clk); n++; end
      while (!(rsp_q.size() == 0 && apb_q.size() == 0 && !busy) && n < 3000);
      total++;
      if (n >= 3000) begin
         bad++;
         $display("FAIL %s_idle_timeout: got pending rsp=%0d apb=%0d expected 0", name, rsp_q.size(), apb_q.size());
      end
      @(posedge clk); #1;
   endtask

   task automatic start_test();
      beat_idx = 0; err_beat = -1; slv_wait = 0;
   endtask

   task automatic check_outputs_zero(input string name);
      chk({name, "_cmd_tready"}, 32'(cmd_tready), 32'd0);
      chk({name, "_rsp_tvalid"}, 32'(rsp_tvalid), 32'd0);
      chk({name, "_rsp_tlast"},  32'(rsp_tlast),  32'd0);
      chk({name, "_rsp_tdata"},  rsp_tdata,       32'd0);
      chk({name, "_psel"},       32'(psel),       32'd0);
      chk({name, "_penable"},    32'(penable),    32'd0);
      chk({name, "_pwrite"},     32'(pwrite),     32'd0);
      chk({name, "_paddr"},      paddr,           32'd0);
      chk({name, "_pstrb"},      32'(pstrb),      32'd0);
      chk({name, "_busy"},       32'(busy),       32'd0);
   endtask

   task automatic read4();
      for (int unsigned i = 0; i < 4; i++) begin
         exp_apb(1'b0, 32'h800 + 32'(4 * i), 32'h0);
         exp_rsp(32'h10 + 32'(i), 1'b0);
      end
      exp_rsp(32'h0000_0004, 1'b1);
      send(32'h0000_0003, 1'b0);
      send(32'h0000_0800, 1'b1);
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      chk("post_reset_tready", 32'(cmd_tready), 32'd1);
      @(posedge clk); #1;

      start_test();
      exp_apb(1'b1, 32'h400, 32'hDEAD_BEEF);
      exp_rsp(32'h0000_0001, 1'b1);
      send(32'h8000_0000, 1'b0); send(32'h0000_0400, 1'b0); send(32'hDEAD_BEEF, 1'b1);
      wait_idle("write1");

      start_test();
      read4();
      wait_idle("read4");

      start_test();
      stall_mode = 1'b1;
      read4();
      wait_idle("read4_stall");
      stall_mode = 1'b0;

      start_test();
      err_beat = 1;
      exp_apb(1'b1, 32'h500, 32'hA1);
      exp_apb(1'b1, 32'h504, 32'hA2);
      exp_rsp(32'h8000_0001, 1'b1);
      send(32'h8000_0002, 1'b0); send(32'h0000_0500, 1'b0);
      send(32'hA1, 1'b0); send(32'hA2, 1'b0); send(32'hA3, 1'b1);
      wait_idle("slverr");

      start_test();
      exp_apb(1'b1, 32'h600, 32'hB1);
      exp_apb(1'b1, 32'h604, 32'hB2);
      exp_rsp(32'hA000_0002, 1'b1);
      send(32'h8000_0003, 1'b0); send(32'h0000_0600, 1'b0);
      send(32'hB1, 1'b0); send(32'hB2, 1'b1);
      wait_idle("early_tlast");

      start_test();
      exp_rsp(32'hA000_0000, 1'b1);
      send(32'h8000_0005, 1'b1);
      wait_idle("hdr_tlast");

      start_test();
      exp_rsp(32'hA000_0000, 1'b1);
      send(32'h0000_0001, 1'b0); send(32'h0000_0100, 1'b0); send(32'h55, 1'b1);
      wait_idle("rd_addr_no_tlast");

      start_test();
      exp_apb(1'b1, 32'h700, 32'hC1);
      exp_rsp(32'hA000_0001, 1'b1);
      send(32'h8000_0000, 1'b0); send(32'h0000_0700, 1'b0);
      send(32'hC1, 1'b0); send(32'hC2, 1'b0); send(32'hC3, 1'b1);
      wait_idle("late_tlast");

      start_test();
      exp_apb(1'b1, 32'hFFFF_FFFC, 32'hD1);
      exp_apb(1'b1, 32'h0000_0000, 32'hD2);
      exp_rsp(32'h0000_0002, 1'b1);
      send(32'h8000_0001, 1'b0); send(32'hFFFF_FFFC, 1'b0);
      send(32'hD1, 1'b0); send(32'hD2, 1'b1);
      wait_idle("addr_wrap");

`ifdef APB_REQUESTER_TIMEOUT_EN
      start_test();
      slv_wait = 1000;
      exp_rsp(32'hC000_0000, 1'b1);
      send(32'h0000_0000, 1'b0); send(32'h0000_0300, 1'b1);
      wait_idle("timeout");
      chk("timeout_access_cycles", 32'(last_run), 32'd16);
`endif

      start_test();
      slv_wait = 1000;
      send(32'h0000_0000, 1'b0); send(32'h0000_0200, 1'b1);
      n = 0;
      do begin @(negedge clk); n++; end while (!(psel && penable) && n < 50);
      chk("mid_access_reached", 32'(psel && penable), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_outputs_zero("mid_reset");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rsp_q.delete(); apb_q.delete();
      @(negedge clk);
      chk("after_reset_tready", 32'(cmd_tready), 32'd1);
      chk("after_reset_busy", 32'(busy), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
